// File: rtl/sudoku_pkg.sv
// Shared sudoku dimensions, readout state encoding and the block-index helper.
// GRID_ORD may be overridden from the command line with +define+GRID_ORD=<n>.
`ifndef GRID_ORD
`define GRID_ORD 3
`endif

package sudoku_pkg;

  localparam int GRID_ORD  = `GRID_ORD;
  localparam int GRID_LEN  = GRID_ORD * GRID_ORD;
  localparam int GRID_AREA = GRID_LEN * GRID_LEN;
  localparam int DIG_W     = $clog2(GRID_LEN + 1);
  localparam int IDX_W     = $clog2(GRID_LEN);

  typedef logic [DIG_W-1:0] digit_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_CAPTURE,
    RD_STREAM,
    RD_DONE
  } rd_state_t;

  function automatic int blockof(input int row, input int col);
    return (row / GRID_ORD) * GRID_ORD + col / GRID_ORD;
  endfunction

endpackage

// File: rtl/grid_readout_if.sv
// Tile readout stream: one tile per valid/ready handshake, tagged with row/column.
interface grid_readout_if #(
  parameter int DIG_W = sudoku_pkg::DIG_W,
  parameter int IDX_W = sudoku_pkg::IDX_W
);

  logic             valid;
  logic             ready;
  logic [DIG_W-1:0] digit;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             last;
  logic             bad;

  modport master (output valid, digit, row, col, last, bad, input ready);
  modport slave  (input valid, digit, row, col, last, bad, output ready);

endinterface

// File: rtl/grid_readout_onehot_to_digit.sv
// One-hot tile value to binary digit: bit k alone -> k+1, zero -> 0, multi-hot -> bad with digit 0.
module onehot_to_digit #(
  parameter int GRID_LEN = sudoku_pkg::GRID_LEN,
  parameter int DIG_W    = sudoku_pkg::DIG_W
) (
  input  logic [GRID_LEN-1:0] onehot,
  output logic [DIG_W-1:0]    digit,
  output logic                bad
);

  logic [DIG_W-1:0] digit_any;

  // OR of k+1 over set bits is exact when only one bit is set; multi-hot is caught separately.
  always_comb begin
    digit_any = '0;
    for (int k = 0; k < GRID_LEN; k++) begin
      if (onehot[k]) digit_any = digit_any | DIG_W'(k + 1);
    end
    bad   = |(onehot & (onehot - GRID_LEN'(1)));
    digit = bad ? '0 : digit_any;
  end

endmodule

// File: rtl/grid_readout.sv
// Snapshots a solved grid and streams it row-major over grid_readout_if; failure sets a sticky flag.
// Optional GRID_READOUT_VERIFY_EN adds verify_ok, a row/column/block uniqueness check of the stream.
module grid_readout #(
  parameter int GRID_ORD  = sudoku_pkg::GRID_ORD,
  parameter int GRID_LEN  = GRID_ORD * GRID_ORD,
  parameter int GRID_AREA = GRID_LEN * GRID_LEN,
  parameter int DIG_W     = $clog2(GRID_LEN + 1),
  parameter int IDX_W     = $clog2(GRID_LEN)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          done_success,
  input  logic                          done_failure,
  input  logic [GRID_AREA*GRID_LEN-1:0] values,
  grid_readout_if.master                out_if,
  output logic                          failed,
  output logic                          busy
`ifdef GRID_READOUT_VERIFY_EN
  ,
  output logic                          verify_ok
`endif
);

  import sudoku_pkg::*;

  localparam int TILE_W = $clog2(GRID_AREA);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID_LEN - 1);

  rd_state_t            state;
  logic [GRID_LEN-1:0]  snap [GRID_AREA];
  logic [IDX_W-1:0]     row;
  logic [IDX_W-1:0]     col;
  logic [IDX_W-1:0]     sel_row;
  logic [IDX_W-1:0]     sel_col;
  logic [TILE_W-1:0]    tile_idx;
  logic [GRID_LEN-1:0]  tile_sel;
  logic [DIG_W-1:0]     conv_digit;
  logic                 conv_bad;

  // Next tile to present: the current index before the first load, else the one after it.
  always_comb begin
    sel_row = row;
    sel_col = col;
    if (out_if.valid) begin
      if (col == LAST_IDX) begin
        sel_col = '0;
        sel_row = row + IDX_W'(1);
      end else begin
        sel_col = col + IDX_W'(1);
      end
    end
    tile_idx = TILE_W'(int'(sel_row) * GRID_LEN + int'(sel_col));
    tile_sel = (tile_idx < TILE_W'(GRID_AREA)) ? snap[tile_idx] : '0;
  end

  onehot_to_digit #(
    .GRID_LEN (GRID_LEN),
    .DIG_W    (DIG_W)
  ) u_conv (
    .onehot (tile_sel),
    .digit  (conv_digit),
    .bad    (conv_bad)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RD_IDLE;
      for (int i = 0; i < GRID_AREA; i++) snap[i] <= '0;
      row          <= '0;
      col          <= '0;
      out_if.valid <= 1'b0;
      out_if.digit <= '0;
      out_if.row   <= '0;
      out_if.col   <= '0;
      out_if.last  <= 1'b0;
      out_if.bad   <= 1'b0;
      failed       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (done_success) begin
            for (int i = 0; i < GRID_AREA; i++) snap[i] <= values[i*GRID_LEN +: GRID_LEN];
            busy  <= 1'b1;
            state <= RD_CAPTURE;
          end else if (done_failure) begin
            failed <= 1'b1;
            state  <= RD_DONE;
          end
        end
        RD_CAPTURE: begin
          row   <= '0;
          col   <= '0;
          state <= RD_STREAM;
        end
        RD_STREAM: begin
          // Outputs move only when nothing is presented yet or the presented tile is accepted.
          if (!out_if.valid || out_if.ready) begin
            if (out_if.valid && out_if.last) begin
              out_if.valid <= 1'b0;
              out_if.digit <= '0;
              out_if.row   <= '0;
              out_if.col   <= '0;
              out_if.last  <= 1'b0;
              out_if.bad   <= 1'b0;
              busy         <= 1'b0;
              state        <= RD_DONE;
            end else begin
              out_if.valid <= 1'b1;
              out_if.digit <= conv_digit;
              out_if.bad   <= conv_bad;
              out_if.row   <= sel_row;
              out_if.col   <= sel_col;
              out_if.last  <= (sel_row == LAST_IDX) && (sel_col == LAST_IDX);
              row          <= sel_row;
              col          <= sel_col;
            end
          end
        end
        RD_DONE: begin
          if (start) begin
            failed <= 1'b0;
            state  <= RD_IDLE;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

`ifdef GRID_READOUT_VERIFY_EN
  logic [GRID_LEN-1:0] row_mask;
  logic [GRID_LEN-1:0] col_mask [GRID_LEN];
  logic [GRID_LEN-1:0] blk_mask [GRID_LEN];
  logic [GRID_LEN-1:0] dig_mask;
  logic [IDX_W-1:0]    blk;

  always_comb begin
    dig_mask = (out_if.digit == '0) ? '0 : (GRID_LEN'(1) << (out_if.digit - DIG_W'(1)));
    blk      = IDX_W'(blockof(int'(out_if.row), int'(out_if.col)));
  end

  // An empty or bad tile also clears verify_ok: a complete grid has no zero digits.
  always_ff @(posedge clock) begin
    if (reset) begin
      verify_ok <= 1'b0;
      row_mask  <= '0;
      for (int i = 0; i < GRID_LEN; i++) begin
        col_mask[i] <= '0;
        blk_mask[i] <= '0;
      end
    end else if (state == RD_CAPTURE) begin
      verify_ok <= 1'b1;
      row_mask  <= '0;
      for (int i = 0; i < GRID_LEN; i++) begin
        col_mask[i] <= '0;
        blk_mask[i] <= '0;
      end
    end else if (state == RD_STREAM && out_if.valid && out_if.ready) begin
      if (out_if.bad || (dig_mask == '0) || |(row_mask & dig_mask) ||
          |(col_mask[out_if.col] & dig_mask) || |(blk_mask[blk] & dig_mask)) begin
        verify_ok <= 1'b0;
      end
      row_mask             <= (out_if.col == LAST_IDX) ? '0 : (row_mask | dig_mask);
      col_mask[out_if.col] <= col_mask[out_if.col] | dig_mask;
      blk_mask[blk]        <= blk_mask[blk] | dig_mask;
    end
  end
`endif

endmodule

// File: doc/grid_readout.md
Name: grid_readout

Overview:
- Sits directly downstream of the tile grid. It consumes the grid's per-tile one-hot values and its done_success / done_failure flags.
- On success it snapshots the whole grid and streams it out one tile per valid/ready handshake, in row-major order, as binary digits tagged with row and column.
- On failure it raises a sticky status flag and streams nothing.
- It decouples the solver from slow consumers such as a UART formatter or a display scanner.

Parameters:
- GRID_ORD, default `GRID_ORD (3): block side length.
- GRID_LEN, default GRID_ORD*GRID_ORD: row/column length; width of a one-hot value.
- GRID_AREA, default GRID_LEN*GRID_LEN: tile count.
- DIG_W, default $clog2(GRID_LEN+1): width of a binary digit.
- IDX_W, default $clog2(GRID_LEN): width of a row/column index.

Ports:
- clock  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  same start strobe that is fed to the grid; re-arms this block.
- done_success  in  1  from the grid.
- done_failure  in  1  from the grid.
- values  in  GRID_AREA*GRID_LEN  row-major flattened tile values; tile i occupies bits [i*GRID_LEN +: GRID_LEN].
- out_valid  out  1  a digit is presented.
- out_ready  in  1  consumer accepts the digit.
- out_digit  out  DIG_W  0 = empty tile; k+1 = one-hot bit k set.
- out_row  out  IDX_W  row of the presented tile.
- out_col  out  IDX_W  column of the presented tile.
- out_last  out  1  high with the final tile (row and column both GRID_LEN-1).
- out_bad  out  1  the presented tile is not one-hot and not zero; out_digit is forced to 0.
- failed  out  1  sticky; the grid reported failure.
- busy  out  1  high in CAPTURE and STREAM.

Behaviour:
- State machine: IDLE, CAPTURE, STREAM, DONE. Reset puts it in IDLE.
- Reset values: all outputs 0; snapshot register cleared; index counters cleared.
- IDLE:
  - done_success=1 → CAPTURE, and the snapshot register loads values on this same edge.
  - Else done_failure=1 → DONE with failed set to 1.
  - Both high in the same cycle: success wins.
- CAPTURE: one cycle; loads the row/column counters with 0. → STREAM.
- STREAM:
  - out_valid=1. Outputs are registered from the snapshot at the current index.
  - First out_valid occurs 2 cycles after the done_success sample.
  - Transfer happens when out_valid & out_ready. On a transfer the column increments; at GRID_LEN-1 the column wraps to 0 and the row increments.
  - A transfer with out_last=1 → DONE. Exactly GRID_AREA transfers occur.
  - Stall: while out_ready=0, all out_* outputs hold stable. out_valid never drops before its transfer.
- DONE: outputs idle (out_valid=0). start=1 → IDLE and clears failed.
- The values input and the grid flags are ignored outside IDLE, so a grid restarting mid-stream does not corrupt the snapshot.
- start while in STREAM is ignored; the stream must finish. Only reset aborts a stream.
- Reset mid-stream returns to IDLE with all outputs 0 on the next edge.
- Digit conversion: priority-free. Exactly one bit k set → k+1. Zero → 0. Multi-hot → out_bad=1 and digit 0.

Optional Feature:
- Macro: GRID_READOUT_VERIFY_EN.
- When defined, adds output verify_ok (1 bit) and accumulates during STREAM:
  - one row mask (cleared at each column wrap),
  - GRID_LEN column masks,
  - GRID_LEN block masks, with block index (row/GRID_ORD)*GRID_ORD + col/GRID_ORD.
  - A transfer whose digit's bit is already set in any applicable mask, or whose out_bad=1, latches verify_ok low.
- verify_ok is valid in DONE after a success stream. It is 1 only if no conflict and no empty tiles occurred. Reset value is 0; it is set to 1 at CAPTURE.
- When undefined, the port and the mask registers are absent.

Decomposition:
- Shared package sudoku_pkg: GRID_ORD / GRID_LEN / GRID_AREA constants mirroring the dimension header, a digit_t typedef, an idx_t typedef, and a blockof(row, col) function. The grid reuses the same function.
- One sub-module: onehot_to_digit (combinational; GRID_LEN in → digit, bad).

Test Plan:
- Solved 9x9 grid with valid one-hot values, done_success pulse, out_ready=1 → first out_valid 2 cycles later; 81 consecutive transfers; digits match the grid; out_last only on (8,8); then DONE, busy=0.
- Same grid with out_ready toggling 1,0,0,1 → outputs stable during stalls; still exactly 81 transfers, in order.
- done_failure=1 in IDLE → failed=1, out_valid never asserts; start=1 → failed=0, IDLE.
- Tile (4,7) = 9'b000000101 → at that transfer out_bad=1 and out_digit=0; with VERIFY_EN, verify_ok=0 in DONE.
- Reset asserted at transfer 40 → next cycle all outputs 0; a fresh done_success then streams from (0,0).
- VERIFY_EN with a duplicate 5 in column 2 → verify_ok=0; with a valid grid → verify_ok=1.
